had_mult_pipe: RTL and testbench



---
 rtl/had_mult_pkg.sv | 18 +
 rtl/had_mult_lane.sv | 34 +++
 rtl/had_mult_pipe.sv | 86 ++++++++
 tb/tb_had_mult_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/had_mult_pkg.sv
// Shared constants and saturation helpers for the Hadamard multiplier.
package had_mult_pkg;

  localparam int unsigned HM_LANES = 4;
  localparam int unsigned HM_W     = 4;
  localparam int unsigned HM_FRAC  = 1;

  // Largest value representable in a signed w-bit lane.
  function automatic int sat_max(input int unsigned w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed w-bit lane.
  function automatic int sat_min(input int unsigned w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/had_mult_lane.sv
// One lane: rescale a 2W-bit product by FRAC, range-check and narrow to W bits.
// HAD_MULT_SAT_EN selects clamping on overflow; otherwise the result wraps.
module had_mult_lane
  import had_mult_pkg::*;
#(
  parameter int unsigned W    = HM_W,
  parameter int unsigned FRAC = HM_FRAC
) (
  input  logic [2*W-1:0] p,
  output logic [W-1:0]   z_c,
  output logic           ovf_c
);

  logic signed [2*W-1:0] s;
  logic                  fits;

  assign s = $signed(p) >>> FRAC;

  // In range when every bit above the lane sign bit equals it.
  assign fits  = (s[2*W-1:W-1] == {(W+1){s[W-1]}});
  assign ovf_c = !fits;

`ifdef HAD_MULT_SAT_EN
  always_comb begin
    z_c = s[W-1:0];
    if (!fits) begin
      z_c = s[2*W-1] ? W'(sat_min(W)) : W'(sat_max(W));
    end
  end
`else
  assign z_c = s[W-1:0];
`endif

endmodule

// File: rtl/had_mult_pipe.sv
// Two-stage pipelined element-wise fixed-point multiplier with valid/ready flow control.
// Build option HAD_MULT_SAT_EN: saturate overflowing lanes instead of wrapping.
module had_mult_pipe
  import had_mult_pkg::*;
#(
  parameter int unsigned LANES = HM_LANES,
  parameter int unsigned W     = HM_W,
  parameter int unsigned FRAC  = HM_FRAC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] x,
  input  logic [LANES*W-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] z,
  output logic [LANES-1:0]   ovf
);

  localparam int unsigned PW = 2 * W;

  logic                  s1_valid;
  logic [LANES*PW-1:0]   s1_p;
  logic [LANES*PW-1:0]   prod_c;
  logic [LANES*W-1:0]    lane_z_c;
  logic [LANES-1:0]      lane_ovf_c;
  logic                  s2_load;
  logic                  s1_load;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  // Lane 0 sits in the MSBs of every packed vector.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    localparam int unsigned XH = (LANES - i) * W - 1;
    localparam int unsigned PH = (LANES - i) * PW - 1;

    logic signed [PW-1:0] xa;
    logic signed [PW-1:0] ya;

    assign xa = PW'($signed(x[XH -: W]));
    assign ya = PW'($signed(y[XH -: W]));
    assign prod_c[PH -: PW] = xa * ya;

    had_mult_lane #(
      .W    (W),
      .FRAC (FRAC)
    ) u_lane (
      .p     (s1_p[PH -: PW]),
      .z_c   (lane_z_c[XH -: W]),
      .ovf_c (lane_ovf_c[LANES-1-i])
    );
  end

  // Stage 1: full-precision products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p <= prod_c;
      end
    end
  end

  // Stage 2: narrowed results, held until accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      ovf       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        z   <= lane_z_c;
        ovf <= lane_ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_had_mult_pipe.sv
// Self-checking bench for had_mult_pipe at default parameters (either saturation build).
module tb_had_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;
  logic [3:0]  ovf;

  had_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] ez;
    logic [3:0]  eo;
  } vec_t;

  vec_t        tbl[7];
  logic [19:0] exp_q[$];
  logic [15:0] sx[$];
  logic [15:0] sy[$];
  bit          mon_en = 1'b0;
  int          accepted;
  int          out_cnt;
  int          first_cyc;
  int          last_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: {z, ovf} for one operand pair.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] zz;
    logic [3:0]  ov;
    logic [3:0]  v;
    int          p;
    int          s;
    zz = '0;
    ov = '0;
    for (int i = 0; i < 4; i++) begin
      p = int'($signed(a[15-4*i -: 4])) * int'($signed(b[15-4*i -: 4]));
      s = p >>> 1;
      v = 4'(s);
      if (s > 7 || s < -8) begin
        ov[3-i] = 1'b1;
`ifdef HAD_MULT_SAT_EN
        v = (s > 7) ? 4'h7 : 4'h8;
`endif
      end
      zz[15-4*i -: 4] = v;
    end
    return {zz, ov};
  endfunction

  // Output scoreboard; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (out_cnt == 0) first_cyc = cycle;
      last_cyc = cycle;
      out_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected none", {z, ovf});
      end else begin
        check("stream_out", 32'({z, ovf}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present queued vectors in order, advancing only on a completed handshake.
  task automatic drive_all(input int budget);
    logic fire;
    int   n;
    n = 0;
    while (sx.size() > 0 && n < budget) begin
      x = sx[0];
      y = sy[0];
      in_valid = 1'b1;
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        exp_q.push_back(model(sx[0], sy[0]));
        void'(sx.pop_front());
        void'(sy.pop_front());
        accepted++;
      end
      n++;
    end
    in_valid = 1'b0;
    check("drive_timeout", 32'(sx.size()), 32'd0);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HAD_MULT_SAT_EN
    tbl[0] = '{16'h38D3, 16'h285F, 16'h378E, 4'b0100};
    tbl[1] = '{16'h8000, 16'h7000, 16'h8000, 4'b1000};
    tbl[4] = '{16'h7777, 16'h7777, 16'h7777, 4'b1111};
    tbl[5] = '{16'h8888, 16'h8888, 16'h7777, 4'b1111};
    tbl[6] = '{16'h9A5C, 16'hE3F6, 16'h78D8, 4'b0101};
`else
    tbl[0] = '{16'h38D3, 16'h285F, 16'h308E, 4'b0100};
    tbl[1] = '{16'h8000, 16'h7000, 16'h4000, 4'b1000};
    tbl[4] = '{16'h7777, 16'h7777, 16'h8888, 4'b1111};
    tbl[5] = '{16'h8888, 16'h8888, 16'h0000, 4'b1111};
    tbl[6] = '{16'h9A5C, 16'hE3F6, 16'h77D4, 4'b0101};
`endif
    tbl[2] = '{16'h1234, 16'h1111, 16'h0112, 4'b0000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000};

    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_z", 32'(z), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: two-edge latency and hand-computed lane results.
    for (int i = 0; i < 7; i++) begin
      check("tbl_in_ready", 32'(in_ready), 32'd1);
      x = tbl[i].x;
      y = tbl[i].y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("tbl_lat1_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("tbl_out_valid", 32'(out_valid), 32'd1);
      check("tbl_z", 32'(z), 32'(tbl[i].ez));
      check("tbl_ovf", 32'(ovf), 32'(tbl[i].eo));
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Backpressure: only two sets absorbed, then release all five in order.
    out_ready = 1'b0;
    accepted = 0;
    out_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      sx.push_back(16'h1111 * 16'(i + 1));
      sy.push_back(16'h2357 + 16'(i * 16'h0F1E));
    end
    fork
      drive_all(60);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_accepted", 32'(accepted), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain(40);
    check("bp_count", 32'(out_cnt), 32'd5);
    check("bp_no_gaps", 32'(last_cyc - first_cyc), 32'd4);

    // Full-rate random stream.
    out_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      sx.push_back(16'($urandom));
      sy.push_back(16'($urandom));
    end
    drive_all(300);
    drain(40);
    check("rate_count", 32'(out_cnt), 32'd100);
    check("rate_consecutive", 32'(last_cyc - first_cyc), 32'd99);

    // Reset with two results in flight.
    out_ready = 1'b0;
    sx.push_back(16'h38D3);
    sy.push_back(16'h285F);
    sx.push_back(16'h7777);
    sy.push_back(16'h7777);
    drive_all(20);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_z", 32'(z), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    out_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    check("mrst_idle", 32'(out_valid), 32'd0);
    sx.push_back(16'h1234);
    sy.push_back(16'h1111);
    drive_all(20);
    drain(20);
    check("mrst_count", 32'(out_cnt), 32'd1);
    check("mrst_z_new", 32'(z), 32'h0112);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
